// File: rtl/spmv_mem_primitives.sv
// Storage primitives for the SpMV MAC intermediator: occupancy XOR RAM, dual-port partial-sum RAM, overflow FIFO.
// Optional simulation-only misuse checks are enabled with `define SPMV_MEM_CHECK_EN.

`ifdef SPMV_MEM_CHECK_EN
module spmv_mem_checker #(
  parameter int AW = 10
) (
  input logic          clk,
  input logic          rst,
  input logic          f_push,
  input logic          f_pop,
  input logic          f_full,
  input logic          f_empty,
  input logic          b_we0,
  input logic          b_we1,
  input logic [AW-1:0] b_addr0,
  input logic [AW-1:0] b_addr1
);
  // report misuse of the FIFO and conflicting block-RAM writes
  always @(posedge clk) begin
    if (!rst) begin
      if (f_push && f_full && !f_pop) $display("ERROR %0t: FIFO push while full", $time);
      if (f_pop && f_empty) $display("ERROR %0t: FIFO pop while empty", $time);
      if (b_we0 && b_we1 && (b_addr0 == b_addr1))
        $display("ERROR %0t: block-RAM dual write to address %0d", $time, b_addr0);
    end
  end
endmodule
`endif

module spmv_mem_primitives #(
  parameter int DATA_WIDTH = 66,
  parameter int DEPTH      = 1024,
  parameter int FIFO_WIDTH = 142,
  parameter int FIFO_DEPTH = 32,
  parameter int AW         = $clog2(DEPTH),
  parameter int CW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  x_wr0,
  input  logic                  x_wr1,
  input  logic [AW-1:0]         x_addr0,
  input  logic [AW-1:0]         x_addr1,
  output logic                  x_q0,
  output logic                  x_q1,
  input  logic                  b_we0,
  input  logic                  b_we1,
  input  logic [AW-1:0]         b_addr0,
  input  logic [AW-1:0]         b_addr1,
  input  logic [DATA_WIDTH-1:0] b_d0,
  input  logic [DATA_WIDTH-1:0] b_d1,
  output logic [DATA_WIDTH-1:0] b_q0,
  output logic [DATA_WIDTH-1:0] b_q1,
  input  logic                  f_push,
  input  logic                  f_pop,
  input  logic [FIFO_WIDTH-1:0] f_d,
  output logic [FIFO_WIDTH-1:0] f_q,
  output logic                  f_full,
  output logic                  f_empty,
  output logic [CW-1:0]         f_count,
  output logic                  f_almost_empty,
  output logic                  f_almost_full
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AE_CNT   = CW'(4);
  localparam logic [CW-1:0] AF_CNT   = CW'(FIFO_DEPTH - 4);
  localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);

  // ---------------- occupancy XOR RAM ----------------
  logic [DEPTH-1:0] xor_mem_r;
  logic [DEPTH-1:0] xor_next_s;

  assign x_q0 = xor_mem_r[x_addr0];
  assign x_q1 = xor_mem_r[x_addr1];

  // two toggles of the same bit cancel, so apply them sequentially to a copy
  always_comb begin
    xor_next_s = xor_mem_r;
    if (x_wr0) begin
      xor_next_s[x_addr0] = ~xor_next_s[x_addr0];
    end else begin
      xor_next_s = xor_next_s;
    end
    if (x_wr1) begin
      xor_next_s[x_addr1] = ~xor_next_s[x_addr1];
    end else begin
      xor_next_s = xor_next_s;
    end
  end

  // occupancy bit register with single-cycle clear
  always_ff @(posedge clk) begin
    if (rst) xor_mem_r <= '0;
    else     xor_mem_r <= xor_next_s;
  end

  // ---------------- dual-port partial-sum RAM ----------------
  logic [DATA_WIDTH-1:0] bram_r [DEPTH];
  logic [DATA_WIDTH-1:0] b_q0_r;
  logic [DATA_WIDTH-1:0] b_q1_r;

  // read-first on both ports; port 1 write is ordered last so it wins a collision
  always_ff @(posedge clk) begin
    b_q0_r <= bram_r[b_addr0];
    b_q1_r <= bram_r[b_addr1];
    if (b_we0) bram_r[b_addr0] <= b_d0;
    if (b_we1) bram_r[b_addr1] <= b_d1;
  end

  assign b_q0 = b_q0_r;
  assign b_q1 = b_q1_r;

  // ---------------- overflow FIFO ----------------
  logic [FIFO_WIDTH-1:0] fifo_mem_r [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]         count_r, count_next_s;
  logic [FIFO_WIDTH-1:0] f_q_r;
  logic                  full_r, empty_r, almost_empty_r, almost_full_r;
  logic                  do_push_s, do_pop_s;

  // a full FIFO still accepts a push when the same cycle frees a slot
  always_comb begin
    do_pop_s  = f_pop && !empty_r;
    do_push_s = f_push && (!full_r || do_pop_s);
    case ({do_push_s, do_pop_s})
      2'b10:   count_next_s = count_r + CW'(1);
      2'b01:   count_next_s = count_r - CW'(1);
      default: count_next_s = count_r;
    endcase
  end

  // FIFO storage, no reset needed since pointers define validity
  always_ff @(posedge clk) begin
    if (do_push_s) fifo_mem_r[wr_ptr_r] <= f_d;
  end

  // pointers, pop data and registered status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r       <= '0;
      rd_ptr_r       <= '0;
      count_r        <= '0;
      f_q_r          <= '0;
      full_r         <= 1'b0;
      empty_r        <= 1'b1;
      almost_empty_r <= 1'b1;
      almost_full_r  <= 1'b0;
    end else begin
      if (do_push_s) wr_ptr_r <= (wr_ptr_r == LAST_PTR) ? '0 : wr_ptr_r + PW'(1);
      if (do_pop_s) begin
        rd_ptr_r <= (rd_ptr_r == LAST_PTR) ? '0 : rd_ptr_r + PW'(1);
        f_q_r    <= fifo_mem_r[rd_ptr_r];
      end
      count_r        <= count_next_s;
      full_r         <= (count_next_s == FULL_CNT);
      empty_r        <= (count_next_s == '0);
      almost_empty_r <= (count_next_s <= AE_CNT);
      almost_full_r  <= (count_next_s >= AF_CNT);
    end
  end

  assign f_q            = f_q_r;
  assign f_full         = full_r;
  assign f_empty        = empty_r;
  assign f_count        = count_r;
  assign f_almost_empty = almost_empty_r;
  assign f_almost_full  = almost_full_r;

`ifdef SPMV_MEM_CHECK_EN
  spmv_mem_checker #(.AW(AW)) u_checker (
    .clk     (clk),
    .rst     (rst),
    .f_push  (f_push),
    .f_pop   (f_pop),
    .f_full  (full_r),
    .f_empty (empty_r),
    .b_we0   (b_we0),
    .b_we1   (b_we1),
    .b_addr0 (b_addr0),
    .b_addr1 (b_addr1)
  );
`endif

endmodule

// File: tb/tb_spmv_mem_primitives.sv
// Directed self-checking bench for spmv_mem_primitives.
module tb_spmv_mem_primitives;
  localparam int DW = 66;
  localparam int AW = 10;
  localparam int FW = 142;
  localparam int CW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          x_wr0, x_wr1;
  logic [AW-1:0] x_addr0, x_addr1;
  logic          x_q0, x_q1;
  logic          b_we0, b_we1;
  logic [AW-1:0] b_addr0, b_addr1;
  logic [DW-1:0] b_d0, b_d1, b_q0, b_q1;
  logic          f_push, f_pop;
  logic [FW-1:0] f_d, f_q;
  logic          f_full, f_empty, f_almost_empty, f_almost_full;
  logic [CW-1:0] f_count;

  int passed = 0;
  int total  = 0;

  spmv_mem_primitives dut (
    .clk(clk), .rst(rst),
    .x_wr0(x_wr0), .x_wr1(x_wr1), .x_addr0(x_addr0), .x_addr1(x_addr1),
    .x_q0(x_q0), .x_q1(x_q1),
    .b_we0(b_we0), .b_we1(b_we1), .b_addr0(b_addr0), .b_addr1(b_addr1),
    .b_d0(b_d0), .b_d1(b_d1), .b_q0(b_q0), .b_q1(b_q1),
    .f_push(f_push), .f_pop(f_pop), .f_d(f_d), .f_q(f_q),
    .f_full(f_full), .f_empty(f_empty), .f_count(f_count),
    .f_almost_empty(f_almost_empty), .f_almost_full(f_almost_full)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    logic [FW-1:0] ones;
    ones = '1;
    rst = 1'b1;
    x_wr0 = 1'b0; x_wr1 = 1'b0; x_addr0 = '0; x_addr1 = '0;
    b_we0 = 1'b0; b_we1 = 1'b0; b_addr0 = '0; b_addr1 = '0; b_d0 = '0; b_d1 = '0;
    f_push = 1'b0; f_pop = 1'b0; f_d = '0;
    tick(); tick();
    rst = 1'b0;
    tick();

    // reset state
    check("rst_empty", f_empty, 1);
    check("rst_full", f_full, 0);
    check("rst_count", f_count, 0);
    check("rst_ae", f_almost_empty, 1);
    check("rst_af", f_almost_full, 0);
    check("rst_fq", f_q, 0);
    check("rst_xq0", x_q0, 0);

    // XOR toggle on address 5, read before and after the edge
    x_addr0 = 10'd5; x_addr1 = 10'd5; x_wr0 = 1'b1;
    check("xor_pre_toggle", x_q0, 0);
    tick();
    x_wr0 = 1'b0;
    check("xor_toggle_q0", x_q0, 1);
    check("xor_toggle_q1", x_q1, 1);
    x_wr0 = 1'b1;
    tick();
    x_wr0 = 1'b0;
    check("xor_untoggle", x_q0, 0);

    // simultaneous toggles
    x_addr0 = 10'd7; x_addr1 = 10'd7; x_wr0 = 1'b1; x_wr1 = 1'b1;
    tick();
    x_wr0 = 1'b0; x_wr1 = 1'b0;
    check("xor_same_addr", x_q0, 0);
    x_addr0 = 10'd3; x_addr1 = 10'd9; x_wr0 = 1'b1; x_wr1 = 1'b1;
    tick();
    x_wr0 = 1'b0; x_wr1 = 1'b0;
    check("xor_diff_a3", x_q0, 1);
    check("xor_diff_a9", x_q1, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("xor_rst_a3", x_q0, 0);
    check("xor_rst_a9", x_q1, 0);

    // block RAM write port 0, read port 1
    b_we0 = 1'b1; b_addr0 = 10'd10; b_d0 = 66'h2A;
    tick();
    b_we0 = 1'b0; b_addr1 = 10'd10;
    tick();
    check("bram_xport_read", b_q1, 66'h2A);

    // dual write to the same address: port 1 wins
    b_we0 = 1'b1; b_we1 = 1'b1; b_addr0 = 10'd4; b_addr1 = 10'd4; b_d0 = 66'h1; b_d1 = 66'h2;
    tick();
    b_we0 = 1'b0; b_we1 = 1'b0;
    tick();
    check("bram_dual_q0", b_q0, 66'h2);
    check("bram_dual_q1", b_q1, 66'h2);

    // read-first on the writing port, then new data visible
    b_we0 = 1'b1; b_addr0 = 10'd10; b_d0 = 66'h5;
    tick();
    b_we0 = 1'b0;
    check("bram_read_first", b_q0, 66'h2A);
    tick();
    check("bram_after_write", b_q0, 66'h5);

    // cross-port read of an address being written returns old data
    b_we0 = 1'b1; b_addr0 = 10'd20; b_d0 = 66'h3_0000_0000_0000_0077;
    tick();
    b_d0 = 66'h88; b_addr1 = 10'd20;
    tick();
    b_we0 = 1'b0;
    check("bram_xport_old", b_q1, 66'h3_0000_0000_0000_0077);
    tick();
    check("bram_xport_new", b_q1, 66'h88);

    // FIFO fill with 0..31
    for (int i = 0; i < 32; i++) begin
      f_d = FW'(i); f_push = 1'b1;
      tick();
      check("fill_count", f_count, i + 1);
      check("fill_af", f_almost_full, (i + 1 >= 28) ? 1 : 0);
      check("fill_ae", f_almost_empty, (i + 1 <= 4) ? 1 : 0);
    end
    check("fill_full", f_full, 1);
    f_d = FW'(99);
    tick();
    f_push = 1'b0;
    check("overpush_count", f_count, 32);
    check("overpush_full", f_full, 1);

    // drain in order
    for (int i = 0; i < 32; i++) begin
      f_pop = 1'b1;
      tick();
      check("drain_data", f_q, i);
      check("drain_count", f_count, 31 - i);
    end
    f_pop = 1'b0;
    check("drain_empty", f_empty, 1);

    // pop on empty
    f_pop = 1'b1;
    tick();
    f_pop = 1'b0;
    check("empty_pop_fq", f_q, 31);
    check("empty_pop_count", f_count, 0);

    // push+pop on empty
    f_d = FW'(256); f_push = 1'b1; f_pop = 1'b1;
    tick();
    f_push = 1'b0; f_pop = 1'b0;
    check("pushpop_empty_count", f_count, 1);
    check("pushpop_empty_fq", f_q, 31);
    f_pop = 1'b1;
    tick();
    f_pop = 1'b0;
    check("pushpop_empty_data", f_q, 256);
    check("pushpop_empty_flag", f_empty, 1);

    // push+pop on full across pointer wrap
    for (int i = 0; i < 32; i++) begin
      f_d = FW'(200 + i); f_push = 1'b1;
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      f_d = FW'(300 + k); f_pop = 1'b1;
      tick();
      check("pushpop_full_data", f_q, 200 + k);
      check("pushpop_full_count", f_count, 32);
    end
    f_push = 1'b0;
    for (int i = 0; i < 32; i++) begin
      tick();
      check("wrap_drain", f_q, (i < 28) ? 204 + i : 300 + i - 28);
    end
    f_pop = 1'b0;
    check("wrap_empty", f_empty, 1);

    // reset mid-fill
    for (int i = 0; i < 10; i++) begin
      f_d = FW'(400 + i); f_push = 1'b1;
      tick();
    end
    f_push = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_empty", f_empty, 1);
    check("midrst_count", f_count, 0);
    check("midrst_fq", f_q, 0);
    f_d = ones; f_push = 1'b1;
    tick();
    f_push = 1'b0; f_pop = 1'b1;
    tick();
    f_pop = 1'b0;
    check("midrst_new_word", f_q, ones);
    check("midrst_final_empty", f_empty, 1);
    check("bram_retained", b_q0, 66'h88);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
